aes512_block_sequencer: RTL
===========================

Name: aes512_block_sequencer

Overview:
- Front-end stage for the 512-bit encryption path; sits directly upstream of the combinational AES-128 core and also collects its results.
- Accepts one 512-bit message and one 128-bit key through a valid/ready handshake.
- Feeds the message to the core one 128-bit block at a time, block 0 first, then blocks 1, 2 and 3.
- Captures each 128-bit core result and presents the assembled 512-bit ciphertext through a valid/ready handshake.

Parameters:
- CORE_LAT, 1: cycles from an aes_data update to sampling aes_result; legal range 1..15; 1 for the combinational core.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  message and key on data_in/key_in are valid.
- in_ready  output  1  block can accept a message this cycle.
- data_in  input  [0:511]  plaintext; bits [0:127] form block 0, [128:255] block 1, [256:383] block 2, [384:511] block 3.
- key_in  input  [0:127]  cipher key.
- iv_in  input  [0:127]  initial vector; used only with AES512_CBC_EN, ignored otherwise.
- aes_data  output  [0:127]  block driven to the core's data input (registered).
- aes_key  output  [0:127]  key driven to the core's key input (registered).
- aes_result  input  [0:127]  core's en_key output.
- out_valid  output  1  out_data holds a complete ciphertext.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  [0:511]  ciphertext in the same block order as data_in.
- busy  output  1  high in RUN and DONE.

Behaviour:
- Reset
  - When rst is high at a clock edge: state goes to IDLE; aes_data, aes_key, out_data, the block index and the latency counter are cleared to 0; out_valid=0, busy=0.
  - in_ready is held 0 while rst is high.
  - Reset mid-operation abandons the message; no partial output is ever presented.
- States: IDLE, RUN, DONE. in_ready = (state==IDLE) & !rst. busy = (state!=IDLE).
- IDLE
  - On in_valid & in_ready: latch data_in, key_in and iv_in.
  - aes_key <= key_in; aes_data <= block 0; blk_idx <= 0; lat_cnt <= 0; go to RUN.
- RUN, per edge
  - If lat_cnt == CORE_LAT-1: capture aes_result into out_data block[blk_idx].
    - If blk_idx==3, go to DONE.
    - Otherwise blk_idx++, aes_data <= next block, lat_cnt <= 0.
  - Otherwise lat_cnt++.
  - aes_key is held stable for the whole message.
- Latency
  - Acceptance happens at edge E. Block k's result is captured at edge E + (k+1)*CORE_LAT.
  - out_valid rises after edge E + 4*CORE_LAT. For CORE_LAT=1 this is 4 cycles.
- DONE
  - out_valid=1; out_data is held stable until the handshake.
  - On out_ready: out_valid <= 0 and go to IDLE. out_data keeps its value but is not meaningful.
  - No new message is accepted in the same cycle as the output handshake. Minimum spacing between accepts is 4*CORE_LAT+2 cycles.
- Ignored inputs: in_valid is ignored outside IDLE. out_ready is ignored outside DONE.
- Block index: 2 bits, never wraps inside a message. Latency counter: 4 bits.

Optional Feature:
- Macro: AES512_CBC_EN.
- Defined: CBC chaining.
  - Block 0 goes to the core as plaintext block 0 XOR iv.
  - Block k (k>0) goes to the core as plaintext block k XOR the captured ciphertext of block k-1. This XOR is applied at the edge that captures block k-1's result.
  - out_data holds the raw core outputs.
- Undefined: ECB mode. Each block is sent unmodified and iv_in has no effect. The port still exists, so the bench stays the same for both builds.

Test Plan:
- ECB, CORE_LAT=1, real core, key 000102030405060708090a0b0c0d0e0f, data_in = four copies of 00112233445566778899aabbccddeeff -> out_data = four copies of 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid high exactly 4 cycles after the accept edge, busy high in between.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_data unchanged, out_valid=1, in_ready=0, and an in_valid pulse is ignored; raise out_ready -> in IDLE the next cycle, in_ready=1.
- CORE_LAT=3, same vector with a stub core that registers its output -> out_valid 12 cycles after accept; aes_data changes only at edges E, E+3, E+6, E+9.
- Reset asserted at the cycle after the second capture -> next cycle state IDLE, out_valid=0, out_data=0, aes_data=0; a new message is then processed correctly from block 0.
- AES512_CBC_EN defined, iv=00112233445566778899aabbccddeeff, block 0 = 0, key as above -> aes_data first = 00112233445566778899aabbccddeeff and out block 0 = 69c4e0d86a7b0430d8cdb78070b4c55a; out blocks 1..3 match the software CBC model.
- Back-to-back messages with in_valid held high and out_ready held high -> second message accepted exactly 6 cycles after the first (CORE_LAT=1), and both outputs are correct.

Source files
------------

// File: rtl/aes512_block_sequencer.sv
// aes512_block_sequencer
// Front end of the 512-bit encryption path. Accepts one 512-bit message and a
// 128-bit key, walks the four 128-bit blocks through an external AES-128 core
// (block 0 first), collects the four results and presents the 512-bit
// ciphertext on a valid/ready output.
//
// Build option: define AES512_CBC_EN to chain blocks in CBC mode (block 0 is
// XORed with iv_in, block k with the ciphertext of block k-1). Without it the
// blocks are sent unmodified (ECB) and iv_in is ignored.
module aes512_block_sequencer #(
   parameter int CORE_LAT = 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [0:511]   data_in,
   input  logic [0:127]   key_in,
   input  logic [0:127]   iv_in,
   output logic [0:127]   aes_data,
   output logic [0:127]   aes_key,
   input  logic [0:127]   aes_result,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [0:511]   out_data,
   output logic           busy
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   // Count value at which the core result for the current block is valid.
   localparam logic [3:0] LAT_LAST = 4'(CORE_LAT - 1);

   logic [1:0]   state;
   logic [1:0]   blk_idx;
   logic [1:0]   blk_nxt;
   logic [3:0]   lat_cnt;
   logic [0:511] msg;
   logic         accept;
   logic         last_lat;
   logic [0:127] first_blk;
   logic [0:127] next_blk;

   assign in_ready  = (state == S_IDLE) & ~rst;
   assign busy      = (state != S_IDLE);
   assign out_valid = (state == S_DONE);
   assign accept    = in_valid & in_ready;
   assign last_lat  = (lat_cnt == LAT_LAST);
   assign blk_nxt   = blk_idx + 2'd1;

`ifdef AES512_CBC_EN
   // CBC: the first block is whitened with the IV, each later block with the
   // ciphertext captured on the same edge the block is launched.
   assign first_blk = data_in[0:127] ^ iv_in;
   assign next_blk  = msg[{blk_nxt, 7'b0} +: 128] ^ aes_result;
`else
   logic unused_iv;
   assign unused_iv = ^iv_in;
   assign first_blk = data_in[0:127];
   assign next_blk  = msg[{blk_nxt, 7'b0} +: 128];
`endif

   // Control: IDLE -> RUN on accept, step through four blocks, DONE until drained.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         blk_idx <= 2'd0;
         lat_cnt <= 4'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  state   <= S_RUN;
                  blk_idx <= 2'd0;
                  lat_cnt <= 4'd0;
               end
            end
            S_RUN: begin
               if (last_lat) begin
                  if (blk_idx == 2'd3) begin
                     state <= S_DONE;
                  end else begin
                     blk_idx <= blk_nxt;
                     lat_cnt <= 4'd0;
                  end
               end else begin
                  lat_cnt <= lat_cnt + 4'd1;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Datapath: latch the message, drive the core, assemble the ciphertext.
   always_ff @(posedge clk) begin
      if (rst) begin
         aes_data <= '0;
         aes_key  <= '0;
         out_data <= '0;
      end else begin
         if (accept) begin
            msg      <= data_in;
            aes_key  <= key_in;
            aes_data <= first_blk;
         end
         if ((state == S_RUN) && last_lat) begin
            out_data[{blk_idx, 7'b0} +: 128] <= aes_result;
            if (blk_idx != 2'd3) begin
               aes_data <= next_blk;
            end
         end
      end
   end

endmodule
